// File: rtl/fifo_wr_arb.sv
// Round-robin write-port arbiter in front of an async FIFO: grants one requester
// at a time for bursts of up to MAX_BURST words and writes only while the FIFO is not full.
module fifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          wclk,
    input  logic                          wrst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          wfull,
    output logic                          wen,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic                          arb_busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [CNT_W-1:0]     burst_cnt_q, burst_cnt_d;
    logic                 busy_q, busy_d;

    logic                 valid_g_s;
    logic                 wen_s;
    logic                 burst_end_s;
    logic                 pick_found_s;
    logic [IDX_W-1:0]     pick_idx_s;
    logic [NUM_REQ-1:0]   pick_oh_s;

    // Rotating search starting after 'from'; 'from' itself is examined last.
    function automatic logic [IDX_W:0] pick_next(input logic [NUM_REQ-1:0] cand,
                                                 input logic [IDX_W-1:0]   from);
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] jj;
        int               j;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = int'(from) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            jj = IDX_W'(j);
            if (!found && cand[jj]) begin
                found = 1'b1;
                idx   = jj;
            end
        end
        return {found, idx};
    endfunction

    // Write-side datapath: the granted requester (always last_q while bursting) feeds the FIFO.
    always_comb begin
        valid_g_s = req_valid[last_q];
        wen_s     = (state_q == ST_BURST) && valid_g_s && !wfull;
        req_ack   = '0;
        if (wen_s) begin
            req_ack[last_q] = 1'b1;
        end else begin
            req_ack = '0;
        end
        if (gnt_q != '0) begin
            wdata = req_data[int'(last_q)*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            wdata = '0;
        end
        {pick_found_s, pick_idx_s} = pick_next(req_valid, last_q);
        pick_oh_s = NUM_REQ'(1) << pick_idx_s;
    end

    // Next-state logic; a dropped grantee is already absent from req_valid, so re-arbitration excludes it.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        burst_end_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_d     = ST_BURST;
                    gnt_d       = pick_oh_s;
                    last_d      = pick_idx_s;
                    burst_cnt_d = '0;
                end else begin
                    gnt_d = '0;
                end
            end
            ST_BURST: begin
                burst_end_s = !valid_g_s ||
                              (wen_s && (burst_cnt_q == CNT_W'(MAX_BURST - 1)));
                if (burst_end_s) begin
                    if (pick_found_s) begin
                        gnt_d       = pick_oh_s;
                        last_d      = pick_idx_s;
                        burst_cnt_d = '0;
                    end else begin
                        state_d     = ST_IDLE;
                        gnt_d       = '0;
                        burst_cnt_d = '0;
                    end
                end else if (wen_s) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end else begin
                    burst_cnt_d = burst_cnt_q;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_d       = '0;
                burst_cnt_d = '0;
            end
        endcase
        busy_d = (state_d == ST_BURST);
    end

    // State registers; reset points last at the top index so requester 0 wins first.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            last_q      <= IDX_W'(NUM_REQ - 1);
            burst_cnt_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign wen      = wen_s;
    assign gnt      = gnt_q;
    assign arb_busy = busy_q;

endmodule
